powerup_ctrl: RTL and testbench
===============================

POWERUP_CTRL -- requirements
Module: powerup_ctrl

Interface
REQ-001 SHALL have parameter SPAWN_DELAY, default 8'd120: frames waited in IDLE before a spawn.
REQ-002 SHALL have parameter ARMED_FRAMES, default 10'd600: frames a pack stays on screen uneaten before it expires.
REQ-003 SHALL have parameter EFFECT_FRAMES, default 10'd300: frames an awarded effect lasts.
REQ-004 SHALL have parameters PP_W = 20, PP_H = 20 and BALL_SIZE = 16: pack and ball box sizes in pixels.
REQ-005 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low; low forces the reset state immediately.
REQ-007 SHALL have port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-008 SHALL have port round_reset, input, 1: one-cycle pulse on a point scored.
REQ-009 SHALL have ports ball_x and ball_y, inputs, 11 and 10 bits: ball top-left corner.
REQ-010 SHALL have port ball_dir, input, 1: last paddle hit; 0 = left player, 1 = right player.
REQ-011 SHALL have ports rx and ry, inputs, 11 and 10 bits: pack top-left corner from the pack renderer.
REQ-012 SHALL have port mode, input, 2 bits: pack type from the renderer; 00 SLOW, 01 BOOST, 10 EXTRA, 11 SHIELD.
REQ-013 SHALL have ports spawn and eaten, outputs, 1 bit each, registered one-cycle pulses to the renderer.
REQ-014 SHALL have port effect_active, output, 1: an effect is currently applied.
REQ-015 SHALL have port effect_mode, output, 2 bits: the type of the applied effect.
REQ-016 SHALL have port effect_owner, output, 1: the player who earned the applied effect.
REQ-017 SHALL have port frames_left, output, 10 bits: frames remaining in the EFFECT state.

Function
REQ-018 SHALL implement the FSM states IDLE, SPAWN, ARMED, EATEN and EFFECT, with a 10-bit frame counter cnt.
REQ-019 IDLE: cnt increments on each frame_tick; when cnt reaches SPAWN_DELAY-1 and frame_tick is high, the FSM goes to SPAWN and cnt clears.
REQ-020 SPAWN: spawn SHALL be high for exactly this one cycle; the next state is ARMED.
REQ-021 ARMED: rx, ry and mode are sampled only on frame_tick cycles; a cycle with frame_tick low has no effect.
REQ-022 Hit test SHALL be the box overlap ball_x < rx+PP_W, rx < ball_x+BALL_SIZE, ball_y < ry+PP_H and ry < ball_y+BALL_SIZE.
REQ-023 The hit-test sums SHALL be computed one bit wider than their operands (12 and 11 bits), so they never wrap.
REQ-024 ARMED, hit on a frame_tick: latch effect_mode <= mode and effect_owner <= ball_dir, then go to EATEN.
REQ-025 ARMED, no hit: cnt increments; if cnt reaches ARMED_FRAMES-1, the pack expires: go to EATEN with award flag cleared.
REQ-026 If a hit and the expiry occur on the same frame_tick, the hit SHALL win and the effect is awarded.
REQ-027 EATEN: eaten SHALL be high for exactly one cycle; next state is EFFECT if the award flag is set, otherwise IDLE; cnt clears.
REQ-028 EFFECT: on entry effect_active = 1 and frames_left = EFFECT_FRAMES; frames_left decrements on each frame_tick.
REQ-029 EFFECT: on the frame_tick where frames_left = 1, frames_left goes to 0, effect_active clears and the FSM returns to IDLE with cnt = 0.
REQ-030 Only one pack or effect SHALL exist at a time; no spawn occurs outside IDLE.
REQ-031 round_reset SHALL have priority over all other events: from any state, go to IDLE, cnt = 0, effect_active = 0, frames_left = 0.
REQ-032 round_reset in ARMED SHALL also pulse eaten for one cycle, to hide the pack, with no effect awarded.
REQ-033 spawn and eaten SHALL never be high in the same cycle.

Reset
REQ-034 With reset low: state = IDLE, cnt = 0, spawn = 0, eaten = 0, effect_active = 0, effect_mode = 00, effect_owner = 0, frames_left = 0.
REQ-035 Reset asserted mid-EFFECT SHALL drop effect_active immediately, without waiting for a clock edge.
REQ-036 After reset release, the first spawn SHALL occur on the SPAWN_DELAY-th frame_tick, with spawn high in the cycle after that tick.

Verification
REQ-037 Bench parameters SHALL be SPAWN_DELAY = 4, ARMED_FRAMES = 10, EFFECT_FRAMES = 6, with frame_tick every 8 clocks.
REQ-038 Release reset -> spawn pulses once, in the cycle after the 4th frame_tick; no other spawn follows while the FSM is in ARMED.
REQ-039 ARMED with rx = 100, ry = 200, mode = 11, ball_x = 90, ball_y = 195, ball_dir = 1, frame_tick -> eaten pulses once; effect_active = 1, effect_mode = 11, effect_owner = 1, frames_left = 6, then decrements to 0 over 6 ticks, then IDLE.
REQ-040 Ball at ball_x = 84, ry = 200 (touching, not overlapping, rx = 100) -> no hit; after 10 ticks, expiry pulses eaten and effect_active stays 0.
REQ-041 Hit on the 10th ARMED tick (coincides with expiry) -> the effect is awarded.
REQ-042 round_reset mid-EFFECT with frames_left = 3 -> effect_active = 0 on the next cycle; the next spawn comes 4 ticks later.
REQ-043 Corner case rx = 2040, ball_x = 5 -> no hit, because the hit-test sums do not wrap.

Source files
------------

// File: rtl/powerup_ctrl.sv
// -----------------------------------------------------------------------------
// powerup_ctrl
// Power-up pack sequencer for the pong game. It waits in IDLE, spawns a pack,
// and keeps it armed until the ball overlaps it or it expires. It then reports
// the pack as eaten and, if it was hit, applies a timed effect owned by the
// player who last touched the ball. Only one pack or effect exists at a time.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low
//   frame_tick     one-cycle pulse per video frame
//   round_reset    one-cycle pulse on a point scored; overrides everything
//   ball_x/ball_y  ball top-left corner
//   ball_dir       last paddle hit (0 left, 1 right)
//   rx/ry/mode     pack position and type from the renderer
//   spawn/eaten    registered one-cycle pulses to the renderer
//   effect_active  an effect is applied
//   effect_mode    type of the applied effect
//   effect_owner   player who earned it
//   frames_left    frames remaining in EFFECT
// -----------------------------------------------------------------------------
module powerup_ctrl #(
    parameter logic [7:0] SPAWN_DELAY   = 8'd120,
    parameter logic [9:0] ARMED_FRAMES  = 10'd600,
    parameter logic [9:0] EFFECT_FRAMES = 10'd300,
    parameter int         PP_W          = 20,
    parameter int         PP_H          = 20,
    parameter int         BALL_SIZE     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        round_reset,
    input  logic [10:0] ball_x,
    input  logic [9:0]  ball_y,
    input  logic        ball_dir,
    input  logic [10:0] rx,
    input  logic [9:0]  ry,
    input  logic [1:0]  mode,
    output logic        spawn,
    output logic        eaten,
    output logic        effect_active,
    output logic [1:0]  effect_mode,
    output logic        effect_owner,
    output logic [9:0]  frames_left
);

    typedef enum logic [2:0] {IDLE, SPAWN, ARMED, EATEN, EFFECT} state_e;

    localparam logic [9:0] SPAWN_LAST = {2'b00, SPAWN_DELAY - 8'd1};
    localparam logic [9:0] ARMED_LAST = ARMED_FRAMES - 10'd1;

    state_e      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        spawn_q, spawn_d;
    logic        eaten_q, eaten_d;
    logic        active_q, active_d;
    logic [1:0]  emode_q, emode_d;
    logic        eown_q, eown_d;
    logic [9:0]  fl_q, fl_d;
    logic        award_q, award_d;

    // Box overlap. Ends are one bit wider than the coordinates so a pack near
    // the right/bottom edge cannot wrap around and match a ball at the origin.
    logic [11:0] rx_end, bx_end;
    logic [10:0] ry_end, by_end;
    logic        hit;

    assign rx_end = {1'b0, rx}     + 12'(PP_W);
    assign bx_end = {1'b0, ball_x} + 12'(BALL_SIZE);
    assign ry_end = {1'b0, ry}     + 11'(PP_H);
    assign by_end = {1'b0, ball_y} + 11'(BALL_SIZE);

    assign hit = ({1'b0, ball_x} < rx_end) && ({1'b0, rx} < bx_end) &&
                 ({1'b0, ball_y} < ry_end) && ({1'b0, ry} < by_end);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        spawn_d  = 1'b0;
        eaten_d  = 1'b0;
        active_d = active_q;
        emode_d  = emode_q;
        eown_d   = eown_q;
        fl_d     = fl_q;
        award_d  = award_q;

        if (round_reset) begin
            state_d  = IDLE;
            cnt_d    = '0;
            active_d = 1'b0;
            fl_d     = '0;
            award_d  = 1'b0;
            // A pack already announced to the renderer must be hidden again.
            eaten_d  = (state_q == ARMED) || (state_q == SPAWN);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        if (cnt_q == SPAWN_LAST) begin
                            state_d = SPAWN;
                            cnt_d   = '0;
                            spawn_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end
                end
                SPAWN: state_d = ARMED;
                ARMED: begin
                    if (frame_tick) begin
                        // Hit is checked first so it beats a same-tick expiry.
                        if (hit) begin
                            emode_d = mode;
                            eown_d  = ball_dir;
                            award_d = 1'b1;
                            state_d = EATEN;
                            eaten_d = 1'b1;
                        end else if (cnt_q == ARMED_LAST) begin
                            award_d = 1'b0;
                            state_d = EATEN;
                            eaten_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end
                end
                EATEN: begin
                    cnt_d   = '0;
                    award_d = 1'b0;
                    if (award_q) begin
                        state_d  = EFFECT;
                        active_d = 1'b1;
                        fl_d     = EFFECT_FRAMES;
                    end else begin
                        state_d = IDLE;
                    end
                end
                EFFECT: begin
                    if (frame_tick) begin
                        if (fl_q <= 10'd1) begin
                            fl_d     = '0;
                            active_d = 1'b0;
                            state_d  = IDLE;
                            cnt_d    = '0;
                        end else begin
                            fl_d = fl_q - 10'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            spawn_q  <= 1'b0;
            eaten_q  <= 1'b0;
            active_q <= 1'b0;
            emode_q  <= 2'b00;
            eown_q   <= 1'b0;
            fl_q     <= '0;
            award_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            spawn_q  <= spawn_d;
            eaten_q  <= eaten_d;
            active_q <= active_d;
            emode_q  <= emode_d;
            eown_q   <= eown_d;
            fl_q     <= fl_d;
            award_q  <= award_d;
        end
    end

    assign spawn         = spawn_q;
    assign eaten         = eaten_q;
    assign effect_active = active_q;
    assign effect_mode   = emode_q;
    assign effect_owner  = eown_q;
    assign frames_left   = fl_q;

endmodule

// File: tb/tb_powerup_ctrl.sv
// -----------------------------------------------------------------------------
// tb_powerup_ctrl
// Scenario bench for powerup_ctrl with SPAWN_DELAY=4, ARMED_FRAMES=10,
// EFFECT_FRAMES=6 and a frame_tick every 8 clocks. Expected spawn/eaten pulses
// are queued as the stimulus is driven; a negedge monitor queues the pulses
// the DUT produces, tagged with the frame count and the delay from the last
// tick, and the two queues are popped and compared after each scenario.
// -----------------------------------------------------------------------------
module tb_powerup_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        round_reset = 1'b0;
    logic [10:0] ball_x = 11'd1000;
    logic [9:0]  ball_y = 10'd500;
    logic        ball_dir = 1'b0;
    logic [10:0] rx = 11'd100;
    logic [9:0]  ry = 10'd200;
    logic [1:0]  mode = 2'b00;
    logic        spawn, eaten, effect_active, effect_owner;
    logic [1:0]  effect_mode;
    logic [9:0]  frames_left;

    powerup_ctrl #(
        .SPAWN_DELAY(8'd4), .ARMED_FRAMES(10'd10), .EFFECT_FRAMES(10'd6),
        .PP_W(20), .PP_H(20), .BALL_SIZE(16)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .round_reset(round_reset), .ball_x(ball_x), .ball_y(ball_y),
        .ball_dir(ball_dir), .rx(rx), .ry(ry), .mode(mode),
        .spawn(spawn), .eaten(eaten), .effect_active(effect_active),
        .effect_mode(effect_mode), .effect_owner(effect_owner),
        .frames_left(frames_left)
    );

    always #5 clk = ~clk;

    // kind: 0 spawn, 1 eaten. dly < 0 skips the delay check; chk enables the
    // effect_mode/effect_owner check.
    typedef struct {
        int         kind;
        int         tick;
        int         dly;
        bit         chk;
        logic [1:0] m;
        logic       own;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  tick_n = 0;
    int  ncyc = 0;
    int  last_tick = 0;
    int  both_hi = 0;

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (frame_tick) begin
            tick_n    = tick_n + 1;
            last_tick = ncyc;
        end
        if (spawn && eaten) both_hi = both_hi + 1;
        if (spawn) obs_q.push_back('{0, tick_n, ncyc - last_tick, 1'b0, effect_mode, effect_owner});
        if (eaten) obs_q.push_back('{1, tick_n, ncyc - last_tick, 1'b0, effect_mode, effect_owner});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One video frame: tick high for one cycle, then seven quiet cycles.
    task automatic frame();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (7) cyc();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic ball_far();
        ball_x = 11'd1000; ball_y = 10'd500; rx = 11'd100; ry = 10'd200;
    endtask

    task automatic ball_on(input logic [1:0] m, input logic dir);
        rx = 11'd100; ry = 10'd200; ball_x = 11'd90; ball_y = 10'd195;
        mode = m; ball_dir = dir;
    endtask

    task automatic push_ev(input int kind, input int tick, input int dly,
                           input bit chk, input logic [1:0] m, input logic own);
        exp_q.push_back('{kind, tick, dly, chk, m, own});
    endtask

    task automatic sb_drain(input string name);
        ev_t e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: no pulse seen, required kind=%0d at tick %0d", name, e.kind, e.tick);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.tick !== e.tick ||
                    (e.dly >= 0 && o.dly !== e.dly) ||
                    (e.chk && (o.m !== e.m || o.own !== e.own))) begin
                    n_err++;
                    $display("FAIL %s: got kind=%0d tick=%0d dly=%0d mode=%0d own=%0d, required kind=%0d tick=%0d dly=%0d mode=%0d own=%0d",
                             name, o.kind, o.tick, o.dly, o.m, o.own, e.kind, e.tick, e.dly, e.m, e.own);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d unexpected pulse(s), first kind=%0d tick=%0d, required none",
                     name, obs_q.size(), obs_q[0].kind, obs_q[0].tick);
            obs_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        n_vec += 6;
        if (spawn !== 1'b0) begin n_err++; $display("FAIL reset_spawn: got %b, required 0", spawn); end
        if (eaten !== 1'b0) begin n_err++; $display("FAIL reset_eaten: got %b, required 0", eaten); end
        if (effect_active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b, required 0", effect_active); end
        if (effect_mode !== 2'b00) begin n_err++; $display("FAIL reset_mode: got %b, required 00", effect_mode); end
        if (effect_owner !== 1'b0) begin n_err++; $display("FAIL reset_owner: got %b, required 0", effect_owner); end
        if (frames_left !== 10'd0) begin n_err++; $display("FAIL reset_frames_left: got %0d, required 0", frames_left); end
        reset = 1'b1;
        cyc();
    endtask

    // First spawn on the 4th tick, then 3 quiet frames in ARMED with no pulse.
    task automatic test_spawn();
        int base = tick_n;
        ball_far();
        push_ev(0, base + 4, 1, 1'b0, 2'b00, 1'b0);
        frames(7);
        sb_drain("first_spawn");
    endtask

    task automatic test_hit();
        int base = tick_n;
        ball_on(2'b11, 1'b1);
        push_ev(1, base + 1, 1, 1'b1, 2'b11, 1'b1);
        frame();
        ball_far();
        n_vec += 4;
        if (effect_active !== 1'b1) begin n_err++; $display("FAIL hit_active: got %b, required 1", effect_active); end
        if (effect_mode !== 2'b11) begin n_err++; $display("FAIL hit_mode: got %b, required 11", effect_mode); end
        if (effect_owner !== 1'b1) begin n_err++; $display("FAIL hit_owner: got %b, required 1", effect_owner); end
        if (frames_left !== 10'd6) begin n_err++; $display("FAIL hit_frames_left: got %0d, required 6", frames_left); end
        for (int k = 1; k <= 6; k++) begin
            frame();
            n_vec += 2;
            if (frames_left !== 10'(6 - k)) begin
                n_err++; $display("FAIL effect_countdown[%0d]: got %0d, required %0d", k, frames_left, 6 - k);
            end
            if (effect_active !== (k < 6)) begin
                n_err++; $display("FAIL effect_active[%0d]: got %b, required %b", k, effect_active, k < 6);
            end
        end
        sb_drain("hit_eaten");
    endtask

    // Near misses only (touching edges and a right-edge pack that must not
    // wrap), so the pack expires on its 10th armed tick with no award.
    task automatic test_expire();
        int base = tick_n;
        int rxs[10];
        int bxs[10];
        int bys[10];
        rxs = '{2040, 2040, 100, 100, 100, 100, 100, 100, 100, 100};
        bxs = '{5, 5, 84, 84, 120, 120, 90, 90, 90, 90};
        bys = '{195, 195, 195, 195, 195, 195, 184, 184, 220, 220};
        ball_far();
        push_ev(0, base + 4, 1, 1'b0, 2'b00, 1'b0);
        push_ev(1, base + 14, 1, 1'b0, 2'b00, 1'b0);
        frames(4);
        for (int i = 0; i < 10; i++) begin
            rx = 11'(rxs[i]); ry = 10'd200;
            ball_x = 11'(bxs[i]); ball_y = 10'(bys[i]);
            frame();
        end
        ball_far();
        n_vec += 2;
        if (effect_active !== 1'b0) begin n_err++; $display("FAIL expire_active: got %b, required 0", effect_active); end
        if (frames_left !== 10'd0) begin n_err++; $display("FAIL expire_frames_left: got %0d, required 0", frames_left); end
        sb_drain("expire");
    endtask

    task automatic test_hit_at_expiry();
        int base = tick_n;
        ball_far();
        push_ev(0, base + 4, 1, 1'b0, 2'b00, 1'b0);
        push_ev(1, base + 14, 1, 1'b1, 2'b01, 1'b0);
        frames(13);
        ball_on(2'b01, 1'b0);
        frame();
        ball_far();
        n_vec += 2;
        if (effect_active !== 1'b1) begin n_err++; $display("FAIL expiry_hit_active: got %b, required 1", effect_active); end
        if (frames_left !== 10'd6) begin n_err++; $display("FAIL expiry_hit_frames_left: got %0d, required 6", frames_left); end
        sb_drain("expiry_hit");
    endtask

    task automatic test_round_reset_effect();
        int base;
        frames(3);
        n_vec++;
        if (frames_left !== 10'd3) begin n_err++; $display("FAIL rr_pre_frames_left: got %0d, required 3", frames_left); end
        round_reset = 1'b1;
        cyc();
        round_reset = 1'b0;
        n_vec += 2;
        if (effect_active !== 1'b0) begin n_err++; $display("FAIL rr_active: got %b, required 0", effect_active); end
        if (frames_left !== 10'd0) begin n_err++; $display("FAIL rr_frames_left: got %0d, required 0", frames_left); end
        repeat (6) cyc();
        base = tick_n;
        push_ev(0, base + 4, 1, 1'b0, 2'b00, 1'b0);
        frames(4);
        sb_drain("rr_effect_respawn");
    endtask

    // round_reset while the pack is armed hides it with an eaten pulse.
    task automatic test_round_reset_armed();
        int base;
        frames(2);
        push_ev(1, tick_n, -1, 1'b0, 2'b00, 1'b0);
        round_reset = 1'b1;
        cyc();
        round_reset = 1'b0;
        repeat (3) cyc();
        n_vec++;
        if (effect_active !== 1'b0) begin n_err++; $display("FAIL rr_armed_active: got %b, required 0", effect_active); end
        base = tick_n;
        push_ev(0, base + 4, 1, 1'b0, 2'b00, 1'b0);
        frames(4);
        sb_drain("rr_armed");
    endtask

    task automatic test_async_reset();
        int base = tick_n;
        ball_on(2'b10, 1'b1);
        push_ev(1, base + 1, 1, 1'b1, 2'b10, 1'b1);
        frame();
        ball_far();
        frame();
        n_vec++;
        if (frames_left !== 10'd5) begin n_err++; $display("FAIL async_pre_frames_left: got %0d, required 5", frames_left); end
        sb_drain("async_hit");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_vec += 3;
        if (effect_active !== 1'b0) begin n_err++; $display("FAIL async_active: got %b, required 0", effect_active); end
        if (frames_left !== 10'd0) begin n_err++; $display("FAIL async_frames_left: got %0d, required 0", frames_left); end
        if (effect_mode !== 2'b00) begin n_err++; $display("FAIL async_mode: got %b, required 00", effect_mode); end
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        base = tick_n;
        push_ev(0, base + 4, 1, 1'b0, 2'b00, 1'b0);
        frames(5);
        sb_drain("post_reset_spawn");
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_hit();
        test_expire();
        test_hit_at_expiry();
        test_round_reset_effect();
        test_round_reset_armed();
        test_async_reset();
        n_vec++;
        if (both_hi !== 0) begin
            n_err++; $display("FAIL spawn_eaten_overlap: got %0d cycles, required 0", both_hi);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
